// File: rtl/int_pkg.sv
// Shared types and constants for the interrupt request arbiter.
package int_pkg;
  localparam int NUM_IRQ          = 4;
  localparam int FLUSH_CYCLES_DEF = 3;

  typedef enum logic [1:0] {
    IDLE,
    BREAK,
    FLUSH
  } state_t;

  typedef logic [1:0] code_t;
endpackage

// File: rtl/int_prio_enc.sv
// Highest-set-bit encoder: returns the index of the most significant set bit and a valid flag.
module int_prio_enc
  import int_pkg::*;
(
  input  logic [NUM_IRQ-1:0] i_vec,
  output code_t              o_idx,
  output logic               o_valid
);

  always_comb begin
    o_idx   = '0;
    o_valid = 1'b0;
    for (int i = 0; i < NUM_IRQ; i++) begin
      if (i_vec[i]) begin
        o_idx   = code_t'(i);
        o_valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/int_req_arb.sv
// Edge-captured interrupt arbiter with break/flush sequencing and an EPC save stack.
// INT_NEST_EN: when defined, higher-priority lines preempt and a 4-deep EPC stack is kept.
//
// state | meaning
// IDLE  | waiting for an eligible, enabled, pipeline-valid take
// BREAK | out_BK asserted for exactly one cycle
// FLUSH | holdoff of FLUSH_CYCLES cycles before the next take
module int_req_arb
  import int_pkg::*;
#(
  parameter int FLUSH_CYCLES = FLUSH_CYCLES_DEF
) (
  input  logic               in_CLK,
  input  logic               in_RST,
  input  logic [NUM_IRQ-1:0] in_IRQ,
  input  logic [NUM_IRQ-1:0] in_MASK,
  input  logic               in_NIE,
  input  logic               in_PCV,
  input  logic [31:0]        in_PC,
  input  logic [NUM_IRQ-1:0] in_IG,
  output logic               out_BK,
  output code_t              out_code,
  output logic [31:0]        out_EPC,
  output logic [NUM_IRQ-1:0] out_ISR
);

  localparam int CNT_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(FLUSH_CYCLES - 1);

  logic [NUM_IRQ-1:0] r_irq_q, r_pend, r_isr;
  logic               r_arm, r_bk;
  code_t              r_code;
  state_t             r_state;
  logic [CNT_W-1:0]   r_cnt;

  logic [NUM_IRQ-1:0] w_rise, w_cand, w_take_oh, w_done_oh;
  code_t              w_win, w_done;
  logic               w_win_v, w_done_v, w_elig, w_take;

  // The first edge after reset only loads the sample, so a line held high through reset is not an edge.
  assign w_rise = r_arm ? (in_IRQ & ~r_irq_q) : '0;
  assign w_cand = r_pend & ~in_MASK;

  int_prio_enc u_win  (.i_vec(w_cand),         .o_idx(w_win),  .o_valid(w_win_v));
  int_prio_enc u_done (.i_vec(in_IG & r_isr),  .o_idx(w_done), .o_valid(w_done_v));

`ifdef INT_NEST_EN
  code_t w_lvl;
  logic  w_lvl_v;
  int_prio_enc u_lvl (.i_vec(r_isr), .o_idx(w_lvl), .o_valid(w_lvl_v));
  assign w_elig = w_win_v && (!w_lvl_v || (w_win > w_lvl));
`else
  assign w_elig = w_win_v && (r_isr == '0);
`endif

  assign w_take    = (r_state == IDLE) && w_elig && in_NIE && in_PCV && (in_IG == '0);
  assign w_take_oh = w_take   ? (NUM_IRQ'(1) << w_win)  : '0;
  assign w_done_oh = w_done_v ? (NUM_IRQ'(1) << w_done) : '0;

  always_ff @(posedge in_CLK or posedge in_RST) begin
    if (in_RST) begin
      r_irq_q <= '0;
      r_arm   <= 1'b0;
      r_pend  <= '0;
      r_isr   <= '0;
    end else begin
      r_irq_q <= in_IRQ;
      r_arm   <= 1'b1;
      r_pend  <= (r_pend & ~w_take_oh) | w_rise;
      r_isr   <= (r_isr & ~w_done_oh) | w_take_oh;
    end
  end

  always_ff @(posedge in_CLK or posedge in_RST) begin
    if (in_RST) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_bk    <= 1'b0;
      r_code  <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_take) begin
            r_state <= BREAK;
            r_bk    <= 1'b1;
            r_code  <= w_win;
          end
        end
        BREAK: begin
          r_state <= FLUSH;
          r_bk    <= 1'b0;
          r_cnt   <= CNT_LOAD;
        end
        FLUSH: begin
          if (r_cnt == '0) r_state <= IDLE;
          else             r_cnt   <= r_cnt - CNT_W'(1);
        end
        default: begin
          r_state <= IDLE;
          r_bk    <= 1'b0;
        end
      endcase
    end
  end

`ifdef INT_NEST_EN
  logic [31:0] r_stk [NUM_IRQ];
  logic [2:0]  r_depth;
  logic [1:0]  w_top_idx;

  assign w_top_idx = r_depth[1:0] - 2'd1;

  always_ff @(posedge in_CLK or posedge in_RST) begin
    if (in_RST) begin
      r_depth <= '0;
      for (int i = 0; i < NUM_IRQ; i++) r_stk[i] <= '0;
    end else if (w_take && (r_depth != 3'd4)) begin
      r_stk[r_depth[1:0]] <= in_PC;
      r_depth             <= r_depth + 3'd1;
    end else if (w_done_v && (r_depth != 3'd0)) begin
      r_depth <= r_depth - 3'd1;
    end
  end

  assign out_EPC = (r_depth == 3'd0) ? '0 : r_stk[w_top_idx];
`else
  logic [31:0] r_epc;

  always_ff @(posedge in_CLK or posedge in_RST) begin
    if (in_RST)        r_epc <= '0;
    else if (w_take)   r_epc <= in_PC;
    else if (w_done_v) r_epc <= '0;
  end

  assign out_EPC = r_epc;
`endif

  assign out_BK   = r_bk;
  assign out_code = r_code;
  assign out_ISR  = r_isr;

endmodule
